simon_iter_core: RTL and testbench

- Iterative Feistel cipher core built on the team's rotate/AND/XOR round.
- Processes one DATAW-bit (L,R) block pair per transaction and applies ROUNDS rounds, one per clock.
- Supports encrypt and decrypt modes.
- Round keys come from an external key store addressed by the core. The core sits between the block-input FIFO and the output packer, with valid/ready on both sides.

---
 rtl/simon_iter_core.sv | 116 +++++++++++
 tb/tb_simon_iter_core.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/simon_iter_core.sv
// simon_iter_core: iterative rotate/AND/XOR Feistel core, one round per clock.
// Encrypts or decrypts one (L,R) block per transaction with external round keys.
module simon_iter_core #(
   parameter int DATAW   = 10,
   parameter int ROUNDS  = 8,
   parameter int RIDXW   = 3,
   parameter int SHIFT_A = 1,
   parameter int SHIFT_B = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [DATAW-1:0] in_l,
   input  logic [DATAW-1:0] in_r,
   output logic [RIDXW-1:0] rk_idx,
   input  logic [DATAW-1:0] rk,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_l,
   output logic [DATAW-1:0] out_r,
   output logic             busy
);

   localparam int SA = SHIFT_A % DATAW;
   localparam int SB = SHIFT_B % DATAW;
   localparam logic [RIDXW-1:0] LAST = RIDXW'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [DATAW-1:0] l_q, l_d;
   logic [DATAW-1:0] r_q, r_d;
   logic [RIDXW-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;

   function automatic logic [DATAW-1:0] rotl(
      input logic [DATAW-1:0] x,
      input int               s
   );
      logic [2*DATAW-1:0] dbl;
      dbl = {x, x};
      return dbl[2*DATAW-1-s -: DATAW];
   endfunction

   function automatic logic [DATAW-1:0] round_f(input logic [DATAW-1:0] x);
      return rotl(x, SA) ^ (x & rotl(x, SB));
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         l_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      l_d       = l_q;
      r_d       = r_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      rk_idx    = '0;
      unique case (state_q)
         IDLE: begin
            // held low while reset is asserted, state already reads IDLE then
            in_ready = rst_n;
            if (in_valid) begin
               l_d     = in_l;
               r_d     = in_r;
               mode_d  = in_mode;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            busy   = 1'b1;
            rk_idx = mode_q ? (LAST - cnt_q) : cnt_q;
            if (mode_q) begin
               l_d = r_q;
               r_d = l_q ^ round_f(r_q) ^ rk;
            end else begin
               l_d = r_q ^ round_f(l_q) ^ rk;
               r_d = l_q;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_l = l_q;
   assign out_r = r_q;

endmodule

// File: tb/tb_simon_iter_core.sv
// tb_simon_iter_core: directed checks of simon_iter_core at ROUNDS=1 and ROUNDS=8.
// The 8-round instance reads keys from a rk[j]=j*0x35 store.
module tb_simon_iter_core;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   logic       in_valid1, in_ready1, in_mode1, out_valid1, out_ready1, busy1;
   logic [9:0] in_l1, in_r1, rk1, out_l1, out_r1;
   logic [0:0] rk_idx1;

   logic       in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, busy8;
   logic [9:0] in_l8, in_r8, rk8, out_l8, out_r8;
   logic [2:0] rk_idx8;

   simon_iter_core #(.DATAW(10), .ROUNDS(1), .RIDXW(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_mode(in_mode1),
      .in_l(in_l1), .in_r(in_r1), .rk_idx(rk_idx1), .rk(rk1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_l(out_l1), .out_r(out_r1), .busy(busy1)
   );

   simon_iter_core dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_mode(in_mode8),
      .in_l(in_l8), .in_r(in_r8), .rk_idx(rk_idx8), .rk(rk8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .out_l(out_l8), .out_r(out_r8), .busy(busy8)
   );

   // key store, combinational return
   assign rk8 = 10'(rk_idx8) * 10'h035;

   function automatic logic [9:0] fm(input logic [9:0] x);
      logic [9:0] a, b;
      a = {x[8:0], x[9]};
      b = {x[4:0], x[9:5]};
      return a ^ (x & b);
   endfunction

   function automatic logic [19:0] enc8(input logic [9:0] l, input logic [9:0] r);
      logic [9:0] t;
      for (int j = 0; j < 8; j++) begin
         t = r ^ fm(l) ^ (10'(j) * 10'h035);
         r = l;
         l = t;
      end
      return {l, r};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run1(input logic m, input logic [9:0] l, input logic [9:0] r,
                       input logic [9:0] key, input logic [19:0] exp);
      chk("r1_ready", {31'd0, in_ready1}, 1);
      in_valid1 = 1'b1; in_mode1 = m; in_l1 = l; in_r1 = r; rk1 = key;
      step();
      in_valid1 = 1'b0; in_l1 = ~l; in_mode1 = ~m;
      chk("r1_busy", {31'd0, busy1}, 1);
      chk("r1_rk_idx", {31'd0, rk_idx1}, 0);
      step();
      chk("r1_valid", {31'd0, out_valid1}, 1);
      chk("r1_result", {12'd0, out_l1, out_r1}, {12'd0, exp});
      out_ready1 = 1'b1;
      step();
      out_ready1 = 1'b0;
      rk1 = 10'h3C3;
   endtask

   task automatic run8(input logic m, input logic [9:0] l, input logic [9:0] r,
                       input logic [19:0] exp);
      int guard;
      guard = 0;
      while (!in_ready8 && guard < 40) begin
         step();
         guard++;
      end
      chk("r8_ready", {31'd0, in_ready8}, 1);
      in_valid8 = 1'b1; in_mode8 = m; in_l8 = l; in_r8 = r;
      step();
      in_valid8 = 1'b0; in_l8 = 10'($urandom); in_r8 = 10'($urandom); in_mode8 = ~m;
      for (int i = 0; i < 8; i++) begin
         chk("r8_rk_idx", {29'd0, rk_idx8}, m ? 32'(7 - i) : 32'(i));
         step();
      end
      chk("r8_valid", {31'd0, out_valid8}, 1);
      chk("r8_result", {12'd0, out_l8, out_r8}, {12'd0, exp});
      out_ready8 = 1'b1;
      step();
      out_ready8 = 1'b0;
   endtask

   initial begin
      logic [9:0]  pl, pr;
      logic [19:0] ct, held;
      logic [19:0] q[$];
      int          last, nacc;
      logic        acc;

      in_valid1 = 0; in_mode1 = 0; in_l1 = 0; in_r1 = 0; rk1 = 0; out_ready1 = 0;
      in_valid8 = 0; in_mode8 = 0; in_l8 = 0; in_r8 = 0; out_ready8 = 0;

      #12;
      chk("rst_in_ready", {31'd0, in_ready8}, 0);
      chk("rst_out_valid", {31'd0, out_valid8}, 0);
      chk("rst_busy", {31'd0, busy8}, 0);
      chk("rst_rk_idx", {29'd0, rk_idx8}, 0);
      chk("rst_out", {12'd0, out_l8, out_r8}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_ready8", {31'd0, in_ready8}, 1);
      chk("post_rst_ready1", {31'd0, in_ready1}, 1);

      run1(1'b0, 10'h001, 10'h000, 10'h000, {10'h002, 10'h001});
      run1(1'b0, 10'h3FF, 10'h155, 10'h0AA, {10'h1FF, 10'h3FF});
      run1(1'b1, 10'h1FF, 10'h3FF, 10'h0AA, {10'h3FF, 10'h155});

      run8(1'b0, 10'h001, 10'h000, enc8(10'h001, 10'h000));
      for (int b = 0; b < 100; b++) begin
         pl = 10'($urandom);
         pr = 10'($urandom);
         ct = enc8(pl, pr);
         run8(1'b0, pl, pr, ct);
         run8(1'b1, ct[19:10], ct[9:0], {pl, pr});
      end

      // backpressure in DONE
      held = enc8(10'h2A5, 10'h0F0);
      in_valid8 = 1'b1; in_mode8 = 1'b0; in_l8 = 10'h2A5; in_r8 = 10'h0F0;
      step();
      in_valid8 = 1'b0;
      repeat (8) step();
      chk("bp_valid", {31'd0, out_valid8}, 1);
      for (int k = 0; k < 5; k++) begin
         in_valid8 = ~in_valid8;
         in_l8 = in_l8 ^ 10'h3FF;
         step();
         chk("bp_hold", {12'd0, out_l8, out_r8}, {12'd0, held});
         chk("bp_in_ready", {31'd0, in_ready8}, 0);
         chk("bp_out_valid", {31'd0, out_valid8}, 1);
      end
      out_ready8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      out_ready8 = 1'b0;
      chk("bp_idle_ready", {31'd0, in_ready8}, 1);
      chk("bp_idle_valid", {31'd0, out_valid8}, 0);

      // reset mid-block
      in_valid8 = 1'b1; in_mode8 = 1'b0; in_l8 = 10'h123; in_r8 = 10'h321;
      step();
      in_valid8 = 1'b0;
      repeat (4) step();
      chk("mid_busy", {31'd0, busy8}, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out", {12'd0, out_l8, out_r8}, 0);
      chk("abort_valid", {31'd0, out_valid8}, 0);
      chk("abort_busy", {31'd0, busy8}, 0);
      chk("abort_rk_idx", {29'd0, rk_idx8}, 0);
      chk("abort_ready", {31'd0, in_ready8}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      run8(1'b0, 10'h123, 10'h321, enc8(10'h123, 10'h321));

      // back-to-back
      out_ready8 = 1'b1; in_valid8 = 1'b1; in_mode8 = 1'b0;
      in_l8 = 10'h050; in_r8 = 10'h3A0;
      last = -1; nacc = 0;
      for (int cyc = 0; cyc < 46; cyc++) begin
         acc = 1'b0;
         if (in_ready8) begin
            if (last >= 0) chk("b2b_spacing", 32'(cyc - last), 10);
            last = cyc;
            nacc++;
            q.push_back(enc8(in_l8, in_r8));
            acc = 1'b1;
         end
         if (out_valid8) begin
            if (q.size() > 0) chk("b2b_order", {12'd0, out_l8, out_r8}, {12'd0, q.pop_front()});
            else chk("b2b_spurious", {31'd0, out_valid8}, 0);
         end
         step();
         if (acc) begin
            in_l8 = in_l8 + 10'h067;
            in_r8 = in_r8 ^ 10'h1C9;
         end
      end
      in_valid8 = 1'b0;
      chk("b2b_count", 32'(nacc), 5);
      repeat (12) step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
